// File: rtl/instr_fetch_pkg.sv
// Shared constants and tag type for the instruction-fetch arbiter.
// Imported by the arbiter top and its round-robin sub-block.
package instr_fetch_pkg;

    localparam int IADDR_W   = 15;
    localparam int IDATA_W   = 16;
    localparam int IMEM_LAT  = 2;
    localparam int MAX_CORES = 8;
    localparam int TAG_ID_W  = $clog2(MAX_CORES);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } fetch_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotate-priority select plus pointer register.
// Winner is the first request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_any,
    output logic [IW-1:0] gnt_id
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   idx;

    // Scan requests starting at ptr, taking the first one found.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (!gnt_any && req[idx[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[IW-1:0];
            end
        end
    end

    assign gnt = gnt_any ? (N'(1) << gnt_id) : '0;

    // Move the pointer just past the winner; hold it when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            if (gnt_id == IW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + IW'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/instr_fetch_arbiter.sv
// Shares one instruction-memory read port among N_CORES fetch units.
// Tags follow each read through the memory latency; flush kills stale ones.
module instr_fetch_arbiter
    import instr_fetch_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int MEM_LAT = IMEM_LAT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CORES-1:0]         req,
    input  logic [N_CORES*IADDR_W-1:0] addr,
    input  logic [N_CORES-1:0]         flush,
    output logic [N_CORES-1:0]         gnt,
    output logic [N_CORES-1:0]         rvalid,
    output logic [IDATA_W-1:0]         rdata,
    output logic [IADDR_W-1:0]         mem_raddr,
    input  logic [IDATA_W-1:0]         mem_rdata
);

    localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [N_CORES-1:0] req_eff;
    logic               arb_any;
    logic [IW-1:0]      arb_id;

    fetch_tag_t tag_q [MEM_LAT];
    fetch_tag_t tag_d [MEM_LAT];

    // Flushed cores sit out this cycle; nothing is granted in reset.
    assign req_eff = rst ? '0 : (req & ~flush);

    rr_arbiter #(
        .N (N_CORES)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_eff),
        .gnt     (gnt),
        .gnt_any (arb_any),
        .gnt_id  (arb_id)
    );

    // Forward the winner's address to memory, zero when idle.
    always_comb begin
        mem_raddr = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (arb_any && arb_id == IW'(i)) begin
                mem_raddr = addr[i*IADDR_W +: IADDR_W];
            end
        end
    end

    // Advance tags, dropping any whose core is flushed this cycle.
    always_comb begin
        tag_d[0].valid = arb_any;
        tag_d[0].id    = TAG_ID_W'(arb_id);
        for (int k = 1; k < MEM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
            if (|(flush & (N_CORES'(1) << tag_q[k-1].id))) begin
                tag_d[k].valid = 1'b0;
            end
        end
    end

    // Tag pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MEM_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    // The oldest tag names the core that owns this cycle's read data.
    always_comb begin
        rvalid = '0;
        if (!rst && tag_q[MEM_LAT-1].valid) begin
            rvalid = N_CORES'(1) << tag_q[MEM_LAT-1].id;
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Bench for instr_fetch_arbiter: directed vector table plus random traffic.
// A queue-based reference model predicts grants, returns and data.
module tb_instr_fetch_arbiter;

    localparam int N  = 4;
    localparam int AW = 15;
    localparam int DW = 16;

    localparam logic [AW-1:0] A0 = 15'h0010;
    localparam logic [AW-1:0] A1 = 15'h0200;
    localparam logic [AW-1:0] A2 = 15'h0300;
    localparam logic [AW-1:0] A3 = 15'h0400;
    localparam logic [N*AW-1:0] AD = {A3, A2, A1, A0};

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    flush;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   mem_raddr;
    logic [DW-1:0]   mem_rdata;

    always #5 clk = ~clk;

    instr_fetch_arbiter #(
        .N_CORES (N),
        .MEM_LAT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .flush     (flush),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 15'h0010) return 16'hBEEF;
        return {a, 1'b0} ^ 16'h3C5A;
    endfunction

    // Two-cycle memory: registered address, then registered data.
    logic [AW-1:0] ma_q;
    always @(posedge clk) begin
        ma_q      <= mem_raddr;
        mem_rdata <= mem_word(ma_q);
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h",
                      nm, cyc, act, exp);
    endtask

    typedef struct {
        int          core;
        logic [AW-1:0] a;
        int          due;
    } fl_t;

    fl_t q[$];
    int  ptr_m = 0;

    // Drive one cycle, check against the model, then advance the model.
    task automatic tick(input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] fl,
                        input logic [N*AW-1:0] ad, output int win);
        logic [N-1:0]  eg;
        logic [AW-1:0] era;
        logic [N-1:0]  erv;
        logic [DW-1:0] erd;
        int c;
        @(negedge clk);
        rst = r; req = rq; flush = fl; addr = ad;
        #1;
        win = -1;
        eg = '0; era = '0; erv = '0; erd = '0;
        if (!r) begin
            for (int k = 0; k < N; k++) begin
                c = (ptr_m + k) % N;
                if (win < 0 && rq[c] && !fl[c]) win = c;
            end
        end
        if (win >= 0) begin
            eg[win] = 1'b1;
            era = ad[win*AW +: AW];
        end
        if (!r && q.size() > 0 && q[0].due == cyc) begin
            erv[q[0].core] = 1'b1;
            erd = mem_word(q[0].a);
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("mem_raddr", 32'(mem_raddr), 32'(era));
        chk("rvalid", 32'(rvalid), 32'(erv));
        if (erv != '0) chk("rdata", 32'(rdata), 32'(erd));
        if (r) begin
            q.delete();
            ptr_m = 0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            for (int j = q.size() - 1; j >= 0; j--) begin
                if (fl[q[j].core]) q.delete(j);
            end
            if (win >= 0) begin
                q.push_back('{core: win, a: era, due: cyc + 2});
                ptr_m = (win + 1) % N;
            end
        end
        cyc++;
    endtask

    typedef struct {
        logic          r;
        logic [N-1:0]  rq;
        logic [N-1:0]  fl;
        logic [N-1:0]  g;
        logic [AW-1:0] ra;
        logic [N-1:0]  rv;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [N-1:0] rq,
                       input logic [N-1:0] fl, input logic [N-1:0] g,
                       input logic [AW-1:0] ra, input logic [N-1:0] rv,
                       input logic [DW-1:0] rd);
        tv.push_back('{r: r, rq: rq, fl: fl, g: g, ra: ra, rv: rv, rd: rd});
    endtask

    logic [N-1:0]    pend;
    logic [N*AW-1:0] paddr;
    logic [N-1:0]    rfl;
    logic            rr;
    int              waitc [N];
    int              w;

    initial begin
        rst = 1'b1; req = '0; flush = '0; addr = '0;

        // reset, single fetch of BEEF
        add(1, 4'b0000, 0, 4'b0000, 0,  4'b0000, 0);
        add(1, 4'b0001, 0, 4'b0000, 0,  4'b0000, 0);
        add(0, 4'b0001, 0, 4'b0001, A0, 4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0,  4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0,  4'b0001, 16'hBEEF);
        add(1, 4'b0000, 0, 4'b0000, 0,  4'b0000, 0);
        // all request, ptr=0
        add(0, 4'b1111, 0, 4'b0001, A0, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0010, A1, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0100, A2, 4'b0001, mem_word(A0));
        add(0, 4'b1111, 0, 4'b1000, A3, 4'b0010, mem_word(A1));
        add(0, 4'b1111, 0, 4'b0001, A0, 4'b0100, mem_word(A2));
        add(0, 4'b1111, 0, 4'b0010, A1, 4'b1000, mem_word(A3));
        add(0, 4'b1111, 0, 4'b0100, A2, 4'b0001, mem_word(A0));
        add(0, 4'b1111, 0, 4'b1000, A3, 4'b0010, mem_word(A1));
        // move ptr to 3, then wrap 3 -> 0
        add(0, 4'b0100, 0, 4'b0100, A2, 4'b0100, mem_word(A2));
        add(0, 4'b1001, 0, 4'b1000, A3, 4'b1000, mem_word(A3));
        add(0, 4'b1001, 0, 4'b0001, A0, 4'b0100, mem_word(A2));
        add(0, 4'b0000, 0, 4'b0000, 0,  4'b1000, mem_word(A3));
        add(0, 4'b0000, 0, 4'b0000, 0,  4'b0001, mem_word(A0));
        // flush core 2 while in flight, core 1 unaffected
        add(0, 4'b0100, 4'b0000, 4'b0100, A2, 4'b0000, 0);
        add(0, 4'b0010, 4'b0100, 4'b0010, A1, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0,  4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0,  4'b0010, mem_word(A1));
        // flush and request same core in the same cycle
        add(0, 4'b0011, 4'b0001, 4'b0010, A1, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0,  4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0,  4'b0010, mem_word(A1));
        // reset with two reads in flight
        add(0, 4'b1000, 0, 4'b1000, A3, 4'b0000, 0);
        add(0, 4'b0001, 0, 4'b0001, A0, 4'b0000, 0);
        add(1, 4'b0110, 0, 4'b0000, 0,  4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0,  4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0,  4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0,  4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0001, A0, 4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0,  4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 0,  4'b0001, 16'hBEEF);

        foreach (tv[i]) begin
            tick(tv[i].r, tv[i].rq, tv[i].fl, AD, w);
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tv[i].g));
            chk($sformatf("vec%0d_raddr", i), 32'(mem_raddr),
                32'(tv[i].ra));
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid),
                32'(tv[i].rv));
            if (tv[i].rv != '0)
                chk($sformatf("vec%0d_rdata", i), 32'(rdata),
                    32'(tv[i].rd));
        end

        // Random traffic: requests held until granted.
        pend = '0;
        paddr = '0;
        foreach (waitc[c]) waitc[c] = 0;
        for (int t = 0; t < 3000; t++) begin
            rr = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c] = 1'b1;
                    paddr[c*AW +: AW] = ($urandom_range(0, 7) == 0) ?
                        15'h0010 : AW'($urandom);
                end
                rfl[c] = ($urandom_range(0, 11) == 0);
            end
            tick(rr, pend, rfl, paddr, w);
            for (int c = 0; c < N; c++) begin
                if (rr || rfl[c] || !pend[c]) waitc[c] = 0;
                else waitc[c]++;
            end
            if (w >= 0) begin
                chk("starve", 32'(waitc[w] <= N), 32'd1);
                waitc[w] = 0;
                pend[w] = 1'($urandom_range(0, 1));
                paddr[w*AW +: AW] = AW'($urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
